cp0_exc_ctrl: RTL and testbench

Coprocessor-0 exception controller for the pipelined MIPS core. Holds SR, Cause, EPC and PRId and arbitrates hardware interrupts against mtc0/eret. It is the producer side of the next-PC redirect interface: it raises the exception request that makes the decoder select the fixed handler vector (NPCOp 3'b101, byte address 0x0000_4180), and it supplies the word-aligned EPC that the next-PC logic consumes on eret (NPCOp 3'b100).

---
 rtl/cp0_exc_ctrl.sv | 131 +++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: MIPS coprocessor-0 exception controller (SR, Cause, EPC, PRId).
// Latency: IntReq and DOut are combinational; register state updates on the next rising edge of clk.
// Backpressure: none; IntReq has priority over the committing eret/mtc0, which are dropped when it fires.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   PC              - word address of the committing instruction (saved into EPC on redirect)
//   DIn, Sel, Wen   - mtc0 data, register number (also the mfc0 read select), commit strobe
//   EretEn          - eret commit strobe
//   HWInt           - level-sensitive hardware interrupt lines 7..2
//   DOut            - mfc0 read data, combinational on Sel
//   EPC             - saved return word address for the next-PC logic
//   IntReq          - redirect request to the handler vector
//   EXL             - exception level flag (SR[1])
// Optional feature macro CP0_EXC_EN: adds ExcReq/ExcCodeIn for synchronous exceptions.

module cp0_exc_ctrl #(
  parameter logic [31:0] PRID_VAL = 32'h4A57_0001,
  parameter logic [29:0] VEC_WORD = 30'h0000_1060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] PC,
  input  logic [31:0] DIn,
  input  logic [4:0]  Sel,
  input  logic        Wen,
  input  logic        EretEn,
  input  logic [7:2]  HWInt,
`ifdef CP0_EXC_EN
  input  logic        ExcReq,
  input  logic [4:0]  ExcCodeIn,
`endif
  output logic [31:0] DOut,
  output logic [31:2] EPC,
  output logic        IntReq,
  output logic        EXL
);

  // The decoder hard-wires the handler address; catch a mismatched override at elaboration.
  if ({VEC_WORD, 2'b00} != 32'h0000_4180) begin : g_vec_chk
    $error("cp0_exc_ctrl: VEC_WORD does not match the decoder handler vector 0x4180");
  end

  localparam logic [4:0] SEL_SR    = 5'd12;
  localparam logic [4:0] SEL_CAUSE = 5'd13;
  localparam logic [4:0] SEL_EPC   = 5'd14;
  localparam logic [4:0] SEL_PRID  = 5'd15;

  // EXL is modelled as the state of a two-state FSM.
  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_HANDLER = 1'b1
  } exl_state_t;

  exl_state_t  r_state;
  logic [5:0]  r_im;
  logic        r_ie;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc_code;
  logic [31:2] r_epc;

  logic        w_int_hit;
  logic        w_exc_hit;
  logic        w_in_handler;
  logic [4:0]  w_take_code;

  assign w_in_handler = (r_state == ST_HANDLER);

  // Raw HWInt is used rather than the IP mirror so the redirect is same-cycle.
  assign w_int_hit = r_ie & ~w_in_handler & (|(HWInt & r_im));

`ifdef CP0_EXC_EN
  // Synchronous exceptions ignore IE but are still blocked inside the handler.
  assign w_exc_hit   = ExcReq & ~w_in_handler;
  assign w_take_code = w_exc_hit ? ExcCodeIn : 5'd0;
`else
  assign w_exc_hit   = 1'b0;
  assign w_take_code = 5'd0;
`endif

  assign IntReq = w_int_hit | w_exc_hit;
  assign EPC    = r_epc;
  assign EXL    = w_in_handler;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_NORMAL;
      r_im       <= 6'd0;
      r_ie       <= 1'b0;
      r_ip       <= 6'd0;
      r_exc_code <= 5'd0;
      r_epc      <= 30'd0;
    end else begin
      r_ip <= HWInt;
      if (IntReq) begin
        // Committing instruction is abandoned: its mtc0/eret never happens.
        r_state    <= ST_HANDLER;
        r_epc      <= PC;
        r_exc_code <= w_take_code;
      end else if (EretEn) begin
        r_state <= ST_NORMAL;
      end else if (Wen) begin
        case (Sel)
          SEL_SR: begin
            r_im    <= DIn[15:10];
            r_ie    <= DIn[0];
            r_state <= DIn[1] ? ST_HANDLER : ST_NORMAL;
          end
          SEL_EPC: begin
            r_epc <= DIn[31:2];
          end
          default: begin
            // Cause, PRId and unmapped registers are read-only.
          end
        endcase
      end
    end
  end

  always_comb begin
    DOut = 32'd0;
    case (Sel)
      SEL_SR:    DOut = {16'd0, r_im, 8'd0, w_in_handler, r_ie};
      SEL_CAUSE: DOut = {16'd0, r_ip, 3'd0, r_exc_code, 2'd0};
      SEL_EPC:   DOut = {r_epc, 2'b00};
      SEL_PRID:  DOut = PRID_VAL;
      default:   DOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: scoreboard bench for cp0_exc_ctrl against a register-level reference model.
// Latency: the driver pushes the expected comb outputs per cycle; the monitor checks them at the falling edge.
// Backpressure: none; one expectation per driven cycle.

module tb_cp0_exc_ctrl;

  localparam logic [31:0] PRID = 32'h4A57_0001;
`ifdef CP0_EXC_EN
  localparam bit EXC_BUILD = 1'b1;
`else
  localparam bit EXC_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:2] pc;
  logic [31:0] din;
  logic [4:0]  sel;
  logic        wen;
  logic        eret;
  logic [7:2]  hw;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] dout;
  logic [31:2] epc;
  logic        int_req;
  logic        exl;

  cp0_exc_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .PC        (pc),
    .DIn       (din),
    .Sel       (sel),
    .Wen       (wen),
    .EretEn    (eret),
    .HWInt     (hw),
`ifdef CP0_EXC_EN
    .ExcReq    (exc_req),
    .ExcCodeIn (exc_code),
`endif
    .DOut      (dout),
    .EPC       (epc),
    .IntReq    (int_req),
    .EXL       (exl)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        int_req;
    logic        exl;
    logic [31:0] epc_byte;
    logic [31:0] dout;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   ncyc  = 0;

  // Reference model: architectural register images as 32-bit words.
  logic [31:0] m_sr;
  logic [31:0] m_cause;
  logic [31:0] m_epc;

  function automatic logic [31:0] m_read(input logic [4:0] s);
    case (s)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, id, got, want);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("intreq", e.id, {31'd0, int_req}, {31'd0, e.int_req});
      chk("exl",    e.id, {31'd0, exl},     {31'd0, e.exl});
      chk("epc",    e.id, {epc, 2'b00},     e.epc_byte);
      chk("dout",   e.id, dout,             e.dout);
    end
  end

  // Drive one cycle (called just after a rising edge), push expectation, advance model at the edge.
  task automatic cyc(input logic r, input logic [31:2] p, input logic [31:0] d, input logic [4:0] s,
                     input logic w, input logic er, input logic [7:2] h,
                     input logic xr, input logic [4:0] xc);
    exp_t e;
    logic take_int, take_exc, take;
    rst = r; pc = p; din = d; sel = s; wen = w; eret = er; hw = h; exc_req = xr; exc_code = xc;

    take_int = m_sr[0] && !m_sr[1] && ((h & m_sr[15:10]) != 6'd0);
    take_exc = EXC_BUILD && xr && !m_sr[1];
    take     = take_int || take_exc;

    e.id       = ncyc;
    e.int_req  = take;
    e.exl      = m_sr[1];
    e.epc_byte = m_epc;
    e.dout     = m_read(s);
    q.push_back(e);

    if (r) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      m_cause[15:10] = h;
      if (take) begin
        m_epc        = {p, 2'b00};
        m_sr[1]      = 1'b1;
        m_cause[6:2] = take_exc ? xc : 5'd0;
      end else if (er) begin
        m_sr[1] = 1'b0;
      end else if (w) begin
        if (s == 5'd12) m_sr  = d & 32'h0000_FC03;
        if (s == 5'd14) m_epc = d & 32'hFFFF_FFFC;
      end
    end
    ncyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] s, input logic [7:2] h);
    cyc(1'b0, 30'h0000_0100, 32'd0, s, 1'b0, 1'b0, h, 1'b0, 5'd0);
  endtask

  initial begin
    m_sr = 0; m_cause = 0; m_epc = 0;
    rst = 1; pc = 0; din = 0; sel = 0; wen = 0; eret = 0; hw = 0; exc_req = 0; exc_code = 0;
    // Initial reset without checks (DUT state undefined before it).
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Dirty every register, then one reset edge.
    cyc(1'b0, 30'h1, 32'hFFFF_FFFF, 5'd12, 1'b1, 1'b0, 6'h00, 1'b0, 5'd0);
    cyc(1'b0, 30'h2, 32'h1234_5678, 5'd14, 1'b1, 1'b0, 6'h3F, 1'b0, 5'd0);
    cyc(1'b1, 30'h3, 32'd0,         5'd13, 1'b0, 1'b0, 6'h3F, 1'b0, 5'd0);
    rd(5'd12, 6'h00); rd(5'd13, 6'h00); rd(5'd14, 6'h00); rd(5'd15, 6'h00);

    // Enable IM2 + IE, then a same-cycle interrupt redirect.
    cyc(1'b0, 30'h10, 32'h0000_0401, 5'd12, 1'b1, 1'b0, 6'h00, 1'b0, 5'd0);
    cyc(1'b0, 30'h0000_0C05, 32'd0, 5'd14, 1'b0, 1'b0, 6'h01, 1'b0, 5'd0);
    rd(5'd14, 6'h00);
    // eret with HWInt low, then SR readback.
    cyc(1'b0, 30'h20, 32'd0, 5'd12, 1'b0, 1'b1, 6'h00, 1'b0, 5'd0);
    rd(5'd12, 6'h00);
    // Interrupt beats a same-cycle mtc0 EPC.
    cyc(1'b0, 30'h0000_0123, 32'hDEAD_BEEC, 5'd14, 1'b1, 1'b0, 6'h01, 1'b0, 5'd0);
    rd(5'd14, 6'h01);
    // eret with interrupt still asserted: re-entry the next cycle with new PC.
    cyc(1'b0, 30'h30, 32'd0, 5'd12, 1'b0, 1'b1, 6'h01, 1'b0, 5'd0);
    cyc(1'b0, 30'h0000_0456, 32'd0, 5'd14, 1'b0, 1'b0, 6'h01, 1'b0, 5'd0);
    cyc(1'b0, 30'h40, 32'd0, 5'd14, 1'b0, 1'b1, 6'h00, 1'b0, 5'd0);
    // Masked line: no request, IP mirror appears in Cause.
    cyc(1'b0, 30'h50, 32'd0, 5'd13, 1'b0, 1'b0, 6'h02, 1'b0, 5'd0);
    rd(5'd13, 6'h00);
    // mtc0 clearing EXL from inside the handler.
    cyc(1'b0, 30'h60, 32'd0, 5'd12, 1'b0, 1'b0, 6'h01, 1'b0, 5'd0);
    cyc(1'b0, 30'h61, 32'h0000_0401, 5'd12, 1'b1, 1'b0, 6'h00, 1'b0, 5'd0);
    rd(5'd12, 6'h00);
    // Synchronous exception with IE=0 (only raises IntReq in the CP0_EXC_EN build).
    cyc(1'b0, 30'h70, 32'h0000_0400, 5'd12, 1'b1, 1'b0, 6'h00, 1'b0, 5'd0);
    cyc(1'b0, 30'h71, 32'd0, 5'd13, 1'b0, 1'b0, 6'h00, 1'b1, 5'd8);
    rd(5'd13, 6'h00);
    rd(5'd12, 6'h00);
    cyc(1'b0, 30'h72, 32'd0, 5'd13, 1'b0, 1'b1, 6'h00, 1'b0, 5'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [4:0]  s;
      logic [31:0] d;
      logic [7:2]  h;
      case ($urandom_range(0, 5))
        0: s = 5'd12;
        1: s = 5'd13;
        2: s = 5'd14;
        3: s = 5'd15;
        4: s = 5'd12;
        default: s = 5'($urandom);
      endcase
      d = $urandom;
      if ($urandom_range(0, 2) == 0) d = d & 32'h0000_FC01;  // mostly EXL=0 SR writes
      h = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      cyc(($urandom_range(0, 60) == 0), 30'($urandom), d, s,
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), h,
          ($urandom_range(0, 10) == 0), 5'($urandom));
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    chk("drain", ncyc, q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d got=running want=finished", ncyc);
    $fatal(1, "timeout");
  end

endmodule
